// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the shared data-memory
// port of dmem_arbiter.
//   m0_* / m1_* : req, wstrb (0 = read), addr, wdata in; gnt, rvalid, rdata out
//   mem_*       : re, wstrb, addr, wd toward the memory; rd back from it
// Modports:
//   slave  - the arbiter's view (requests and mem_rd in, grants and mem drive out)
//   master - the requester/memory-model view (the mirror image)
interface dmem_arbiter_if;
  logic        m0_req,    m1_req;
  logic [3:0]  m0_wstrb,  m1_wstrb;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic        m0_gnt,    m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;
  logic        mem_re;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  m0_req, m0_wstrb, m0_addr, m0_wdata,
    input  m1_req, m1_wstrb, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_re, mem_wstrb, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output m0_req, m0_wstrb, m0_addr, m0_wdata,
    output m1_req, m1_wstrb, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_re, mem_wstrb, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between two requesters.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if.slave (requester ports + memory port)
// Parameters:
//   RD_LATENCY   (1..3)   memory read latency in cycles
//   ARB_MODE     (0/1)    0 = round-robin, 1 = port 0 priority w/ starvation guard
//   STARVE_LIMIT (1..255) denied cycles of port 1 before it is force-granted
// Grants are combinational; read data returns on the tagged port's rvalid
// exactly RD_LATENCY cycles after the accepting edge.
module dmem_arbiter #(
  parameter int RD_LATENCY   = 1,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 8
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic                  last_q, last_d;          // most recently granted port
  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic [RD_LATENCY-1:0] pv_q, pv_d;              // read pipeline: valid
  logic [RD_LATENCY-1:0] pp_q, pp_d;              // read pipeline: port tag
  logic                  gnt0, gnt1;

  // Grant decision. Reset overrides everything so no access slips into the
  // memory while rst is high.
  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.m0_req && bus.m1_req) begin
        if (ARB_MODE == 0) begin
          // Tie goes to whichever port did not win last.
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt1 = (starve_cnt_q == LIMIT);
          gnt0 = !gnt1;
        end
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  // Memory drive muxed from the granted port; idle cycles drive all zeros.
  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wd    = 32'h0;
    if (gnt0) begin
      bus.mem_re    = (bus.m0_wstrb == 4'h0);
      bus.mem_wstrb = bus.m0_wstrb;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wd    = bus.m0_wdata;
    end else if (gnt1) begin
      bus.mem_re    = (bus.m1_wstrb == 4'h0);
      bus.mem_wstrb = bus.m1_wstrb;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wd    = bus.m1_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;

    // Counts denied cycles of a waiting port 1; any grant to it, or it
    // withdrawing, restarts the count.
    starve_cnt_d = starve_cnt_q;
    if (!bus.m1_req || gnt1)   starve_cnt_d = 8'h0;
    else if (starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 8'h1;

    pv_d    = pv_q;
    pp_d    = pp_q;
    pv_d[0] = bus.mem_re;
    pp_d[0] = gnt1;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pp_d[i] = pp_q[i-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= 1'b1;   // port 0 wins the first tie after reset
      starve_cnt_q <= 8'h0;
      pv_q         <= '0;     // drops any reads in flight
      pp_q         <= '0;
    end else begin
      last_q       <= last_d;
      starve_cnt_q <= starve_cnt_d;
      pv_q         <= pv_d;
      pp_q         <= pp_d;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = pv_q[RD_LATENCY-1] && !pp_q[RD_LATENCY-1];
  assign bus.m1_rvalid = pv_q[RD_LATENCY-1] &&  pp_q[RD_LATENCY-1];
  assign bus.m0_rdata  = bus.mem_rd;
  assign bus.m1_rdata  = bus.mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter in three configurations:
//   dut_a: RD_LATENCY=1, round-robin
//   dut_b: RD_LATENCY=2, fixed priority, STARVE_LIMIT=3
//   dut_c: RD_LATENCY=3, round-robin
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if ifa ();
  dmem_arbiter_if ifb ();
  dmem_arbiter_if ifc ();

  dmem_arbiter #(.RD_LATENCY(1), .ARB_MODE(0), .STARVE_LIMIT(8))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dmem_arbiter #(.RD_LATENCY(2), .ARB_MODE(1), .STARVE_LIMIT(3))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  dmem_arbiter #(.RD_LATENCY(3), .ARB_MODE(0), .STARVE_LIMIT(8))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else             passed++;
  endtask

  typedef struct {
    logic        m0_req;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr;
    logic        g0, g1, rv0, rv1, re;
    logic [3:0]  wstrb;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[10];

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_wd;
    logic [14:0] fp_m1req;
    logic [14:0] fp_g1;
    logic        rv0_exp, rv1_exp;

    // Round-robin vectors for dut_a (applied one per cycle right after reset).
    //            m0 req/wstrb/addr      m1 req/wstrb/addr      g0 g1 rv0 rv1 re wstrb addr
    vecs[0] = '{1, 4'h0, 32'h100, 1, 4'h0, 32'h200, 1, 0, 0, 0, 1, 4'h0, 32'h100};
    vecs[1] = '{1, 4'h0, 32'h100, 1, 4'h0, 32'h200, 0, 1, 1, 0, 1, 4'h0, 32'h200};
    vecs[2] = '{1, 4'h0, 32'h100, 1, 4'h0, 32'h200, 1, 0, 0, 1, 1, 4'h0, 32'h100};
    vecs[3] = '{1, 4'h0, 32'h100, 1, 4'h0, 32'h200, 0, 1, 1, 0, 1, 4'h0, 32'h200};
    vecs[4] = '{0, 4'h0, 32'h000, 1, 4'hF, 32'h300, 0, 1, 0, 1, 0, 4'hF, 32'h300};
    vecs[5] = '{0, 4'h0, 32'h000, 1, 4'hF, 32'h304, 0, 1, 0, 0, 0, 4'hF, 32'h304};
    vecs[6] = '{1, 4'h0, 32'h108, 1, 4'h0, 32'h208, 1, 0, 0, 0, 1, 4'h0, 32'h108};
    vecs[7] = '{0, 4'h0, 32'h000, 0, 4'h0, 32'h000, 0, 0, 1, 0, 0, 4'h0, 32'h000};
    vecs[8] = '{1, 4'h0, 32'h10C, 1, 4'h0, 32'h20C, 0, 1, 0, 0, 1, 4'h0, 32'h20C};
    vecs[9] = '{1, 4'h8, 32'h044, 0, 4'h0, 32'h000, 1, 0, 0, 1, 0, 4'h8, 32'h044};

    {ifa.m0_req, ifa.m1_req, ifb.m0_req, ifb.m1_req, ifc.m0_req, ifc.m1_req} = '0;
    ifa.m0_wstrb = 0; ifa.m1_wstrb = 0; ifa.m0_addr = 0; ifa.m1_addr = 0;
    ifa.m0_wdata = 0; ifa.m1_wdata = 0; ifa.mem_rd = 0;
    ifb.m0_wstrb = 0; ifb.m1_wstrb = 0; ifb.m0_addr = 32'h500; ifb.m1_addr = 32'h600;
    ifb.m0_wdata = 0; ifb.m1_wdata = 0; ifb.mem_rd = 0;
    ifc.m0_wstrb = 0; ifc.m1_wstrb = 0; ifc.m0_addr = 0; ifc.m1_addr = 0;
    ifc.m0_wdata = 0; ifc.m1_wdata = 0; ifc.mem_rd = 0;

    // Reset state: requests held high must still see no grant and idle memory.
    ifa.m0_req = 1; ifa.m1_req = 1; ifa.m0_addr = 32'h55; ifa.m1_addr = 32'h66;
    #12;
    check("rst g0",    32'(ifa.m0_gnt), 0);
    check("rst g1",    32'(ifa.m1_gnt), 0);
    check("rst re",    32'(ifa.mem_re), 0);
    check("rst wstrb", 32'(ifa.mem_wstrb), 0);
    check("rst addr",  ifa.mem_addr, 0);
    check("rst rv0",   32'(ifa.m0_rvalid), 0);
    check("rst rv1",   32'(ifa.m1_rvalid), 0);
    ifa.m0_req = 0; ifa.m1_req = 0;
    do_reset();

    // Table-driven round-robin / memory-drive / read-return vectors.
    for (int i = 0; i < 10; i++) begin
      ifa.m0_req   = vecs[i].m0_req;   ifa.m1_req   = vecs[i].m1_req;
      ifa.m0_wstrb = vecs[i].m0_wstrb; ifa.m1_wstrb = vecs[i].m1_wstrb;
      ifa.m0_addr  = vecs[i].m0_addr;  ifa.m1_addr  = vecs[i].m1_addr;
      ifa.m0_wdata = ~vecs[i].m0_addr; ifa.m1_wdata = ~vecs[i].m1_addr;
      ifa.mem_rd   = 32'hC0DE_0000 + 32'(i);
      exp_wd = vecs[i].g0 ? ~vecs[i].m0_addr : (vecs[i].g1 ? ~vecs[i].m1_addr : 32'h0);
      #1;
      check($sformatf("row%0d g0", i),    32'(ifa.m0_gnt),    32'(vecs[i].g0));
      check($sformatf("row%0d g1", i),    32'(ifa.m1_gnt),    32'(vecs[i].g1));
      check($sformatf("row%0d rv0", i),   32'(ifa.m0_rvalid), 32'(vecs[i].rv0));
      check($sformatf("row%0d rv1", i),   32'(ifa.m1_rvalid), 32'(vecs[i].rv1));
      check($sformatf("row%0d re", i),    32'(ifa.mem_re),    32'(vecs[i].re));
      check($sformatf("row%0d wstrb", i), 32'(ifa.mem_wstrb), 32'(vecs[i].wstrb));
      check($sformatf("row%0d addr", i),  ifa.mem_addr,       vecs[i].addr);
      check($sformatf("row%0d wd", i),    ifa.mem_wd,         exp_wd);
      check($sformatf("row%0d rdata0", i), ifa.m0_rdata, 32'hC0DE_0000 + 32'(i));
      check($sformatf("row%0d rdata1", i), ifa.m1_rdata, 32'hC0DE_0000 + 32'(i));
      @(negedge clk);
    end
    ifa.m0_req = 0; ifa.m1_req = 0;
    #1;
    check("tail rv0", 32'(ifa.m0_rvalid), 0);
    check("tail rv1", 32'(ifa.m1_rvalid), 0);
    @(negedge clk);

    // Single port 0 read with 1-cycle latency.
    ifa.m0_req = 1; ifa.m0_wstrb = 0; ifa.m0_addr = 32'h40; ifa.mem_rd = 32'hDEADBEEF;
    #1;
    check("p0rd gnt",  32'(ifa.m0_gnt), 1);
    check("p0rd re",   32'(ifa.mem_re), 1);
    check("p0rd addr", ifa.mem_addr, 32'h40);
    @(negedge clk);
    ifa.m0_req = 0;
    #1;
    check("p0rd rv0",   32'(ifa.m0_rvalid), 1);
    check("p0rd rdata", ifa.m0_rdata, 32'hDEADBEEF);
    check("p0rd rv1",   32'(ifa.m1_rvalid), 0);
    @(negedge clk);
    #1;
    check("p0rd rv0 once", 32'(ifa.m0_rvalid), 0);

    // Idle for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check($sformatf("idle%0d re", c),    32'(ifa.mem_re), 0);
      check($sformatf("idle%0d wstrb", c), 32'(ifa.mem_wstrb), 0);
      check($sformatf("idle%0d addr", c),  ifa.mem_addr, 0);
    end

    // Fixed priority with starvation guard (dut_b, limit 3). Port 0 always
    // requests; port 1 withdraws for one cycle at index 10, which must
    // restart its starvation count.
    do_reset();
    fp_m1req = 15'b111_1011_1111_1111;
    fp_g1    = 15'b100_0000_1000_1000;
    ifb.m0_req = 1;
    for (int c = 0; c < 15; c++) begin
      ifb.m1_req = fp_m1req[c];
      #1;
      check($sformatf("fp%0d g1", c), 32'(ifb.m1_gnt), 32'(fp_g1[c]));
      check($sformatf("fp%0d g0", c), 32'(ifb.m0_gnt), 32'(!fp_g1[c]));
      @(negedge clk);
    end
    ifb.m0_req = 0; ifb.m1_req = 0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-cycle with a read in flight (dut_b, latency 2).
    ifb.m1_req = 1; ifb.m1_addr = 32'h80;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst g1",    32'(ifb.m1_gnt), 0);
    check("arst re",    32'(ifb.mem_re), 0);
    check("arst addr",  ifb.mem_addr, 0);
    check("arst wstrb", 32'(ifb.mem_wstrb), 0);
    check("arst rv0",   32'(ifb.m0_rvalid), 0);
    check("arst rv1",   32'(ifb.m1_rvalid), 0);
    @(negedge clk);
    ifb.m1_req = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("arst post%0d rv1", c), 32'(ifb.m1_rvalid), 0);
      check($sformatf("arst post%0d rv0", c), 32'(ifb.m0_rvalid), 0);
      @(negedge clk);
    end

    // Back-to-back mixed traffic on dut_c (latency 3): cycle 1 m0 read 0x10,
    // cycle 2 m1 write 0x20 strobes 0011, cycle 3 m1 read 0x20.
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      ifc.m0_req = (c == 1);
      ifc.m0_addr = 32'h10; ifc.m0_wstrb = 4'h0;
      ifc.m1_req = (c == 2) || (c == 3);
      ifc.m1_addr = 32'h20;
      ifc.m1_wstrb = (c == 2) ? 4'b0011 : 4'h0;
      rv0_exp = (c == 4);
      rv1_exp = (c == 6);
      #1;
      check($sformatf("mix%0d wstrb", c), 32'(ifc.mem_wstrb), (c == 2) ? 32'h3 : 32'h0);
      check($sformatf("mix%0d rv0", c),   32'(ifc.m0_rvalid), 32'(rv0_exp));
      check($sformatf("mix%0d rv1", c),   32'(ifc.m1_rvalid), 32'(rv1_exp));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
